quadrature_decoder: RTL

- Upstream stage of the n-bit up/down/load counter: turns raw quadrature-encoder inputs A, B and Index into the counter's control inputs.
- Counter-side outputs:
  - en: one-cycle step pulse.
  - up: direction level.
  - load: one-cycle preset pulse.
  - D: preset value.
- Inputs are asynchronous to clk. The block synchronizes them, glitch-filters them, decodes Gray-code transitions and flags illegal jumps.

---
 rtl/qdec_pkg.sv | 52 +++++
 rtl/qdec_glitch_filter.sv | 62 ++++++
 rtl/quadrature_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/qdec_pkg.sv
// Shared types and helpers for the quadrature decoder: FSM states, Gray positions
// and the forward-step lookup used to classify A/B transitions.
package qdec_pkg;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } qdec_state_e;

    typedef enum logic [1:0] {
        StepNone,
        StepFwd,
        StepRev,
        StepIllegal
    } qdec_step_e;

    // Positions are {a, b}; forward rotation is 00 -> 10 -> 11 -> 01 -> 00.
    localparam logic [1:0] POS_00 = 2'b00;
    localparam logic [1:0] POS_10 = 2'b10;
    localparam logic [1:0] POS_11 = 2'b11;
    localparam logic [1:0] POS_01 = 2'b01;

    localparam int unsigned FILT_CNT_W = 4;
    localparam int unsigned INIT_CNT_W = 3;

    function automatic logic [1:0] next_fwd(input logic [1:0] pos);
        logic [1:0] nxt;
        nxt = POS_00;
        unique case (pos)
            POS_00: nxt = POS_10;
            POS_10: nxt = POS_11;
            POS_11: nxt = POS_01;
            POS_01: nxt = POS_00;
        endcase
        return nxt;
    endfunction

    function automatic qdec_step_e classify_step(input logic [1:0] prev, input logic [1:0] cur);
        qdec_step_e step;
        if (cur == prev) begin
            step = StepNone;
        end else if (cur == next_fwd(prev)) begin
            step = StepFwd;
        end else if (prev == next_fwd(cur)) begin
            step = StepRev;
        end else begin
            step = StepIllegal;
        end
        return step;
    endfunction

endpackage

// File: rtl/qdec_glitch_filter.sv
// One encoder channel: SYNC_STAGES-deep synchronizer followed by a stability filter that
// only accepts a new level after FILT_LEN consecutive cycles of disagreement.
module qdec_glitch_filter
    import qdec_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    input  logic preset,
    output logic sync,
    output logic filt
);

    localparam logic [FILT_CNT_W-1:0] FiltLast = FILT_CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q, filt_d;
    logic [FILT_CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (preset) begin
            // Startup snapshot: adopt the synchronized level without filtering delay.
            filt_d = sync;
            cnt_d  = '0;
        end else if (sync == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == FiltLast) begin
            filt_d = sync;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end producing en/up/load/D for an up/down/load counter.
// Define QDEC_X1_MODE_EN for 1x decoding (rising A only); default build decodes 4x.
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned n           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3,
    parameter logic [n-1:0] LOAD_VAL   = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         idx_in,
    input  logic         clr_err,
    output logic         en,
    output logic         up,
    output logic         load,
    output logic [n-1:0] D,
    output logic         err
);

    localparam logic [INIT_CNT_W-1:0] InitLast = INIT_CNT_W'(SYNC_STAGES);

    logic a_s, b_s, i_s;
    logic a_f, b_f, i_f;
    logic preset;

    qdec_state_e            state_q, state_d;
    logic [INIT_CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [1:0]             prev_ab_q, prev_ab_d;
    logic                   prev_i_q, prev_i_d;
    logic                   en_q, en_d;
    logic                   up_q, up_d;
    logic                   load_q, load_d;
    logic                   err_q, err_d;

    logic [1:0] ab_f;
    qdec_step_e step;
    logic       step_en;
    logic       err_set;
    logic       idx_rise;

    assign preset = (state_q == StInit) && (init_cnt_q == InitLast);

    qdec_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filt_a (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (a_in),
        .preset  (preset),
        .sync    (a_s),
        .filt    (a_f)
    );

    qdec_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filt_b (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (b_in),
        .preset  (preset),
        .sync    (b_s),
        .filt    (b_f)
    );

    qdec_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filt_i (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (idx_in),
        .preset  (preset),
        .sync    (i_s),
        .filt    (i_f)
    );

    assign ab_f = {a_f, b_f};
    assign step = classify_step(prev_ab_q, ab_f);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_ab_d  = prev_ab_q;
        prev_i_d   = prev_i_q;
        up_d       = up_q;
        en_d       = 1'b0;
        load_d     = 1'b0;
        step_en    = 1'b0;
        err_set    = 1'b0;
        idx_rise   = 1'b0;

        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == InitLast) begin
                    // Take the resting position as the reference so nothing fires on entry.
                    state_d    = StRun;
                    init_cnt_d = '0;
                    prev_ab_d  = {a_s, b_s};
                    prev_i_d   = i_s;
                end
            end
            StRun: begin
                prev_ab_d = ab_f;
                prev_i_d  = i_f;
                idx_rise  = i_f & ~prev_i_q;
`ifdef QDEC_X1_MODE_EN
                if ((step == StepFwd || step == StepRev) && !prev_ab_q[1] && a_f) begin
                    step_en = 1'b1;
                    up_d    = ~b_f;
                end
                if (step == StepIllegal) begin
                    err_set = 1'b1;
                end
`else
                unique case (step)
                    StepFwd: begin
                        step_en = 1'b1;
                        up_d    = 1'b1;
                    end
                    StepRev: begin
                        step_en = 1'b1;
                        up_d    = 1'b0;
                    end
                    StepIllegal: err_set = 1'b1;
                    StepNone:    ;
                endcase
`endif
                // Index wins over a coincident step so the counter lands on LOAD_VAL.
                load_d = idx_rise;
                en_d   = step_en & ~idx_rise;
            end
        endcase

        err_d = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            prev_ab_q  <= POS_00;
            prev_i_q   <= 1'b0;
            en_q       <= 1'b0;
            up_q       <= 1'b1;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_ab_q  <= prev_ab_d;
            prev_i_q   <= prev_i_d;
            en_q       <= en_d;
            up_q       <= up_d;
            load_q     <= load_d;
            err_q      <= err_d;
        end
    end

    assign en   = en_q;
    assign up   = up_q;
    assign load = load_q;
    assign err  = err_q;
    assign D    = LOAD_VAL;

endmodule
